demux_2_stream: RTL and testbench

//  1-to-2 stream demultiplexer; inverse of the 2-way selector. Steers one input word to

---
 rtl/demux_pkg.sv | 11 +
 rtl/demux_out_slot.sv | 27 ++
 rtl/demux_2_stream.sv | 76 +++++++
 tb/tb_demux_2_stream.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
package demux_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int CNT_WIDTH      = 16;

  typedef logic chan_sel_t;
  localparam chan_sel_t CH0 = 1'b0;
  localparam chan_sel_t CH1 = 1'b1;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register slot: load has priority over drain, so a refill and a drain
// can happen on the same edge.
module demux_out_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  drain,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (full && drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_2_stream.sv
// 1-to-2 valid/ready stream demultiplexer with a register slot per output.
// Optional handshake counters on each output when DEMUX_2_COUNT_EN is defined.
module demux_2_stream
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  chan_sel_t             select,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out1_valid,
  input  logic                  out1_ready
`ifdef DEMUX_2_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  out0_count,
  output logic [CNT_WIDTH-1:0]  out1_count
`endif
);

  logic [1:0]                 ready_v;
  logic [1:0]                 full;
  logic [1:0]                 load;
  logic [1:0][DATA_WIDTH-1:0] data;
  logic                       accept;

  assign ready_v = {out1_ready, out0_ready};

  // Only the selected slot gates the input; no path from in_valid.
  assign in_ready = !full[select] || ready_v[select];
  assign accept   = in_valid && in_ready;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_ch
      assign load[g] = accept && (select == chan_sel_t'(g));

      demux_out_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[g]),
        .load_data (in_data),
        .drain     (ready_v[g]),
        .full      (full[g]),
        .data      (data[g])
      );
    end
  endgenerate

  assign out0_valid = full[0];
  assign out0_data  = data[0];
  assign out1_valid = full[1];
  assign out1_data  = data[1];

`ifdef DEMUX_2_COUNT_EN
  logic [1:0][CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (full[i] && ready_v[i]) cnt[i] <= cnt[i] + CNT_WIDTH'(1);
    end
  end

  assign out0_count = cnt[0];
  assign out1_count = cnt[1];
`endif

endmodule

// File: tb/tb_demux_2_stream.sv
// Scoreboard bench for demux_2_stream; define DEMUX_2_COUNT_EN to also cover the counters.
module tb_demux_2_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        select;
  logic [31:0] out0_data, out1_data;
  logic        out0_valid, out1_valid;
  logic        out0_ready, out1_ready;
`ifdef DEMUX_2_COUNT_EN
  logic [15:0] out0_count, out1_count;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];

  demux_2_stream #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .select     (select),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef DEMUX_2_COUNT_EN
    ,
    .out0_count (out0_count),
    .out1_count (out1_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change at negedge+1; the monitor samples at negedge+3, just before the next edge.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    #3;
    if (rst_n) begin
      if (out0_valid && out0_ready) begin
        if (exp0.size() == 0) begin
          checks++; failures++;
          $display("FAIL ch0_unexpected got=%h expected=none", out0_data);
        end else begin
          e = exp0.pop_front();
          chk("ch0_scoreboard", out0_data, e);
        end
      end
      if (out1_valid && out1_ready) begin
        if (exp1.size() == 0) begin
          checks++; failures++;
          $display("FAIL ch1_unexpected got=%h expected=none", out1_data);
        end else begin
          e = exp1.pop_front();
          chk("ch1_scoreboard", out1_data, e);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  // Called at negedge+1; returns at negedge+1 after the accepting edge with in_valid still high.
  task automatic send(input logic [31:0] d, input logic s);
    int n = 0;
    in_data = d; select = s; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout got=in_ready_low expected=accept data=%h", d);
      in_valid = 1'b0;
      #1;
      return;
    end
    if (s) exp1.push_back(d); else exp0.push_back(d);
    @(negedge clk); #1;
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; select = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_data", out0_data, 32'd0);
    chk("rst_out1_data", out1_data, 32'd0);
    rst_n = 1'b1;
    step();

    // Steering
    out0_ready = 1'b1; out1_ready = 1'b1;
    send(32'h00000001, 1'b0);
    chk("steer_out0_valid", 32'(out0_valid), 32'd1);
    chk("steer_out0_data", out0_data, 32'h00000001);
    send(32'h00000010, 1'b1);
    chk("steer_out0_drained", 32'(out0_valid), 32'd0);
    chk("steer_out1_valid", 32'(out1_valid), 32'd1);
    chk("steer_out1_data", out1_data, 32'h00000010);
    idle();
    chk("steer_out1_drained", 32'(out1_valid), 32'd0);

    // Backpressure on ch0, then drain and refill on the same edge
    out0_ready = 1'b0;
    send(32'hFFFFFFFF, 1'b0);
    in_data = 32'hAAAA5555; select = 1'b0; in_valid = 1'b1;
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    repeat (3) begin
      step();
      chk("bp_hold_data", out0_data, 32'hFFFFFFFF);
      chk("bp_hold_valid", 32'(out0_valid), 32'd1);
    end
    out0_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 32'(in_ready), 32'd1);
    exp0.push_back(32'hAAAA5555);
    step();
    chk("bp_refill_data", out0_data, 32'hAAAA5555);
    chk("bp_refill_valid", 32'(out0_valid), 32'd1);
    idle();
    chk("bp_drained", 32'(out0_valid), 32'd0);

    // Independence: ch0 stalled and full must not block ch1
    out0_ready = 1'b0;
    send(32'h11111111, 1'b0);
    send(32'hAAAA5555, 1'b1);
    chk("ind_out1_valid", 32'(out1_valid), 32'd1);
    chk("ind_out1_data", out1_data, 32'hAAAA5555);
    chk("ind_out0_valid", 32'(out0_valid), 32'd1);
    chk("ind_out0_data", out0_data, 32'h11111111);
    in_valid = 1'b0; select = 1'b0;
    #1;
    chk("ind_ch0_blocks", 32'(in_ready), 32'd0);
    out0_ready = 1'b1;
    idle(); idle();

    // Throughput: one accept per cycle
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(32'hC0DE0000 + 32'(i), 1'(i % 2));
    chk("tput_cycles", 32'(cyc - t0), 32'd8);
    idle(); idle();

    // Reset mid-run with both slots full
    out0_ready = 1'b0; out1_ready = 1'b0;
    send(32'h00000005, 1'b0);
    send(32'h00000006, 1'b1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("mid_rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("mid_rst_out0_data", out0_data, 32'd0);
    chk("mid_rst_out1_data", out1_data, 32'd0);
    exp0.delete(); exp1.delete();
`ifdef DEMUX_2_COUNT_EN
    chk("mid_rst_cnt0", 32'(out0_count), 32'd0);
    chk("mid_rst_cnt1", 32'(out1_count), 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();

`ifdef DEMUX_2_COUNT_EN
    out1_ready = 1'b1; out0_ready = 1'b1;
    for (int i = 0; i < 65537; i++) send(32'(i), 1'b1);
    idle(); idle();
    chk("cnt1_wrap", 32'(out1_count), 32'd1);
    chk("cnt0_idle", 32'(out0_count), 32'd0);
`endif

    out0_ready = 1'b1; out1_ready = 1'b1;
    idle(); idle();
    chk("sb_ch0_empty", 32'(exp0.size()), 32'd0);
    chk("sb_ch1_empty", 32'(exp1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
